// File: rtl/huffman_ctrl_pkg.sv
// Shared types and constants for the 6-symbol Huffman controller slice.
// Holds the controller state encoding and the datapath sizing constants
// used by the sorter, selector and splitter blocks.
package huffman_ctrl_pkg;

  localparam int unsigned NUM_SYM          = 6;
  localparam int unsigned SORT_DATA_LENGTH = 7;
  localparam int unsigned SORT_FLAG_LENGTH = 6;
  localparam int unsigned NUM_W            = 3;
  localparam int unsigned ITER_W           = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SORT   = 3'd2,
    ST_MERGE  = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/huffman_ctrl_wdog.sv
// Settle-wait watchdog: counts enabled cycles since the last clear and flags
// when the current cycle is the last one allowed before a timeout.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_clr         restart the count at zero (wins over i_en)
//   i_en          count this cycle
//   o_expired_c   count has reached TIMEOUT-1 (combinational)
module huffman_ctrl_wdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  logic [CNT_W-1:0] r_count;

  // Saturates once expired so the flag cannot wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired_c) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired_c = (r_count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/huffman_ctrl.sv
// Sequencing FSM for the 6-symbol Huffman datapath (sorter, last-pair
// selector, merger, code/mask splitter). On start it loads and sorts the
// counts, then runs five merge iterations, ending with a one-cycle done.
// Outputs are Moore-decoded from state and num_reg, so an asynchronous
// reset drops every strobe immediately.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin encoding (sampled in IDLE and ERROR)
//   sort_done           sorter register equals its sorted output
//   sort_set            sorter load/refresh strobe
//   sort_num            active element count presented to the sorter
//   update_en           sorter merge-update strobe
//   sel_num             element count for the last-pair selector
//   split_rst           clears splitter HC/M registers
//   split_en            splitter shift enable
//   iter                merges completed (0..5)
//   busy                high except in IDLE and ERROR
//   done                one-cycle completion pulse
//   err                 sticky sort-timeout flag (held in ERROR)
module huffman_ctrl
  import huffman_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SYM      = 6,
  parameter int unsigned SORT_TIMEOUT = 16,
  parameter int unsigned TO_W         = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sort_done,
  output logic              sort_set,
  output logic [NUM_W-1:0]  sort_num,
  output logic              update_en,
  output logic [NUM_W-1:0]  sel_num,
  output logic              split_rst,
  output logic              split_en,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [NUM_W-1:0]  NUM_INIT = NUM_W'(NUM_SYM);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(NUM_SYM - 1);

  if (NUM_SYM != 6) begin : g_bad_num_sym
    $error("huffman_ctrl: NUM_SYM must be 6");
  end
  if ((2 ** TO_W) <= SORT_TIMEOUT) begin : g_bad_to_w
    $error("huffman_ctrl: TO_W too narrow for SORT_TIMEOUT");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [NUM_W-1:0]  r_num;
  logic [NUM_W-1:0]  w_num_nxt;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] w_iter_nxt;
  logic              r_guard;
  logic              w_guard_nxt;
  logic              w_wdog_clr;
  logic              w_wdog_en;
  logic              w_wdog_expired;

  huffman_ctrl_wdog #(
    .TIMEOUT (SORT_TIMEOUT),
    .CNT_W   (TO_W)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_wdog_clr),
    .i_en        (w_wdog_en),
    .o_expired_c (w_wdog_expired)
  );

  // State and loop registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_num   <= NUM_INIT;
      r_iter  <= '0;
      r_guard <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_num   <= w_num_nxt;
      r_iter  <= w_iter_nxt;
      r_guard <= w_guard_nxt;
    end
  end

  // Next-state, loop-register updates and Moore output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_iter_nxt  = r_iter;
    w_guard_nxt = r_guard;
    w_wdog_clr  = 1'b0;
    w_wdog_en   = 1'b0;
    sort_set    = 1'b0;
    update_en   = 1'b0;
    split_rst   = 1'b0;
    split_en    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    sort_num    = r_num;
    sel_num     = r_num;

    case (r_state)
      ST_IDLE: begin
        w_wdog_clr = 1'b1;
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_num_nxt   = NUM_INIT;
          w_iter_nxt  = '0;
        end
      end

      ST_LOAD: begin
        busy        = 1'b1;
        sort_set    = 1'b1;
        split_rst   = 1'b1;
        sort_num    = NUM_INIT;
        w_wdog_clr  = 1'b1;
        w_guard_nxt = 1'b1;
        w_state_nxt = ST_SORT;
      end

      // The first SORT cycle sees a stale sorter comparison, so sort_done
      // and the timeout are both ignored while guard is set.
      ST_SORT: begin
        busy        = 1'b1;
        w_wdog_en   = 1'b1;
        w_guard_nxt = 1'b0;
        if (!r_guard) begin
          if (sort_done) begin
            w_state_nxt = ST_MERGE;
          end else if (w_wdog_expired) begin
            w_state_nxt = ST_ERROR;
          end
        end
      end

      // Merged entry lands in the new last slot, hence sort_num = num-1.
      ST_MERGE: begin
        busy      = 1'b1;
        split_en  = 1'b1;
        update_en = 1'b1;
        sort_num  = r_num - NUM_W'(1);
        if (r_num > NUM_W'(1)) begin
          w_num_nxt = r_num - NUM_W'(1);
        end
        if (r_iter < ITER_MAX) begin
          w_iter_nxt = r_iter + ITER_W'(1);
        end
        if (r_num <= NUM_W'(2)) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_SORT;
          w_guard_nxt = 1'b1;
          w_wdog_clr  = 1'b1;
        end
      end

      ST_FINISH: begin
        busy        = 1'b1;
        done        = 1'b1;
        sort_num    = NUM_W'(1);
        w_state_nxt = ST_IDLE;
      end

      ST_ERROR: begin
        err        = 1'b1;
        w_wdog_clr = 1'b1;
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_num_nxt   = NUM_INIT;
          w_iter_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign iter = r_iter;

endmodule

// File: tb/tb_huffman_ctrl.sv
// Scoreboard bench for huffman_ctrl: each run pushes its expected strobe
// events (kind, cycle, counts, iter, busy, err) into a queue; a monitor on
// the falling edge pops and compares whenever the DUT raises a strobe.
module tb_huffman_ctrl;

  localparam int K_SET  = 0;
  localparam int K_UPD  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int cyc;
    int snum;
    int sel;
    int iter;
    int busy;
    int err;
  } evt_t;

  evt_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sort_done = 1'b0;
  logic       sort_set;
  logic [2:0] sort_num;
  logic       update_en;
  logic [2:0] sel_num;
  logic       split_rst;
  logic       split_en;
  logic [2:0] iter;
  logic       busy;
  logic       done;
  logic       err;
  logic       prev_err = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sd_mode = 0;
  int sd_c0 = 0;

  huffman_ctrl #(
    .NUM_SYM      (6),
    .SORT_TIMEOUT (16),
    .TO_W         (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sort_done (sort_done),
    .sort_set  (sort_set),
    .sort_num  (sort_num),
    .update_en (update_en),
    .sel_num   (sel_num),
    .split_rst (split_rst),
    .split_en  (split_en),
    .iter      (iter),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic void push_evt(int kind, int c, int snum, int sel, int it, int bz, int er);
    evt_t e;
    e.kind = kind; e.cyc = c; e.snum = snum; e.sel = sel;
    e.iter = it; e.busy = bz; e.err = er;
    exp_q.push_back(e);
  endfunction

  // LOAD at c0+1, MERGE k at c0+1+per*k, FINISH one cycle after the fifth.
  function automatic void push_run(int c0, int per, int nupd);
    push_evt(K_SET, c0 + 1, 6, 6, 0, 1, 0);
    for (int k = 1; k <= nupd; k++)
      push_evt(K_UPD, c0 + 1 + per * k, 6 - k, 7 - k, k - 1, 1, 0);
    if (nupd == 5)
      push_evt(K_DONE, c0 + 2 + 5 * per, 1, 1, 5, 1, 0);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_evt(input int kind);
    evt_t e;
    int aux;
    case (kind)
      K_SET:   aux = int'(split_rst && !update_en && !split_en);
      K_UPD:   aux = int'(split_en && !sort_set && !split_rst);
      default: aux = int'(!sort_set && !update_en && !split_en);
    endcase
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d, required no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.snum != int'(sort_num) ||
          e.sel != int'(sel_num) || e.iter != int'(iter) ||
          e.busy != int'(busy) || e.err != int'(err) || aux != 1) begin
        bad++;
        $display("FAIL event_%0d: got kind=%0d cyc=%0d sort_num=%0d sel_num=%0d iter=%0d busy=%0d err=%0d aux=%0d required kind=%0d cyc=%0d sort_num=%0d sel_num=%0d iter=%0d busy=%0d err=%0d aux=1",
                 e.kind, kind, cyc, sort_num, sel_num, iter, busy, err, aux,
                 e.kind, e.cyc, e.snum, e.sel, e.iter, e.busy, e.err);
      end
    end
  endtask

  // Monitor: any strobe or a rising err is an observable event.
  always @(negedge clk) begin
    if (sort_set)  check_evt(K_SET);
    if (update_en) check_evt(K_UPD);
    if (done)      check_evt(K_DONE);
    if (err && !prev_err) check_evt(K_ERR);
    prev_err <= err;
  end

  // sort_done driver: 0 = held low, 1 = held high, 2 = guard-cycle glitch
  // followed by two low cycles then high.
  initial begin
    int off;
    forever begin
      @(negedge clk);
      case (sd_mode)
        0: sort_done = 1'b0;
        1: sort_done = 1'b1;
        default: begin
          off = cyc - sd_c0;
          if (off < 2) sort_done = 1'b0;
          else begin
            case ((off - 2) % 5)
              0, 3:    sort_done = 1'b1;
              default: sort_done = 1'b0;
            endcase
          end
        end
      endcase
    end
  end

  task automatic start_run(input int per, input int nupd, input int mode, output int c0);
    @(negedge clk);
    c0 = cyc;
    sd_mode = mode;
    sd_c0 = c0;
    push_run(c0, per, nupd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_until(input int t);
    int n = 0;
    while (cyc < t && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_until_cycle", cyc, t);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_flags", int'({busy, sort_set, update_en, split_rst, split_en, done, err}), 0);
      chk("idle_sort_num", int'(sort_num), 6);
      chk("idle_sel_num_iter", int'({sel_num, iter}), 6 << 3);
    end

    // Fast path: sort_done tied high, 17 cycles LOAD..done.
    start_run(3, 5, 1, c0);
    wait_drain("fast_run_drain", 40);

    // Guard-cycle glitch followed by slow settle.
    start_run(5, 5, 2, c0);
    wait_drain("slow_run_drain", 60);

    // Sort never settles: ERROR after 16 SORT cycles.
    start_run(3, 0, 0, c0);
    push_evt(K_ERR, c0 + 18, 6, 6, 0, 0, 1);
    wait_drain("timeout_drain", 40);
    chk("timeout_err", int'(err), 1);
    chk("timeout_busy", int'(busy), 0);
    start_run(3, 5, 1, c0);
    chk("restart_err_cleared", int'(err), 0);
    wait_drain("restart_drain", 40);

    // start during the iter=2 SORT phase is ignored.
    start_run(3, 5, 1, c0);
    wait_until(c0 + 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignored_start_drain", 40);

    // Asynchronous reset during MERGE.
    start_run(3, 1, 1, c0);
    wait_until(c0 + 4);
    #1;
    chk("pre_rst_update_en", int'(update_en), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_update_en", int'(update_en), 0);
    chk("async_rst_split_en", int'(split_en), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_iter", int'(iter), 0);
    chk("post_rst_sort_num", int'(sort_num), 6);
    chk("post_rst_sel_num", int'(sel_num), 6);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_queue", exp_q.size(), 0);
    exp_q.delete();
    start_run(3, 5, 1, c0);
    wait_drain("post_rst_run_drain", 40);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
